reservation_station_array: RTL and testbench
============================================

RESERVATION_STATION_ARRAY -- requirements
Module: reservation_station_array

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries, 2..16.
REQ-002 SHALL have parameter ROB_SIZE, default 8: number of CDB slots and ROB tags; tag width TAG_W = clog2(ROB_SIZE).
REQ-003 SHALL have parameter XLEN, default 32: operand and data width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- load_word  in  1  allocate res_in this cycle.
- res_in  in  tomasula_types::res_word  incoming op, funct3, funct7, src tags/data/valid, rd_tag, pc.
- cdb  in  tomasula_types::cdb_data[ROB_SIZE]  broadcast data, indexed by tag.
- robs_calculated  in  ROB_SIZE  tag result present on cdb.
- allocated_rob_entries  in  ROB_SIZE  tag still live in ROB.
- exe_ready  in  1  ALU accepts an issue this cycle.
- res_full  out  1  no free entry.
- res_empty  out  1  no valid entry.
- start_exe  out  1  alu_data valid.
- alu_data  out  tomasula_types::alu_word  issued operation.
- jalr_executed, ld_pc_to_cdb, update_br  out  1 each  issue-side decode flags.

Function
REQ-006 SHALL allocate into the lowest-index free entry when load_word=1 and res_full=0; load_word while res_full=1 SHALL be dropped with no entry altered.
REQ-007 res_full and res_empty SHALL be derived from registered valid bits only; an entry freed in cycle N SHALL be allocatable no earlier than N+1.
REQ-008 Every cycle, each valid entry with srcX_valid=0 and robs_calculated[srcX_tag]=1 SHALL capture cdb[srcX_tag].data and set srcX_valid at the next edge.
REQ-009 Allocation SHALL also apply REQ-008 to res_in in the same cycle, so an operand broadcast during allocation is not missed.
REQ-010 An entry is ready when both operands are valid (registered, or per REQ-022).
REQ-011 Select SHALL pick the oldest ready entry, where oldest means allocated earliest; ties are impossible.
REQ-012 start_exe SHALL be 1 iff a ready entry exists; alu_data, derived combinationally from the selected entry, SHALL be held stable while exe_ready=0.
REQ-013 Handshake: the selected entry is freed at the edge where start_exe=1 and exe_ready=1; otherwise it is retained.
REQ-014 alu_data.funct3 SHALL be 3'b000 for JAL and JALR, and res_word.funct3 otherwise.
REQ-015 Flags SHALL be qualified by start_exe:
- ld_pc_to_cdb for JAL, JALR, BRANCH, AUIPC, LUI.
- jalr_executed for JALR.
- update_br for BRANCH.
REQ-016 Flush: any valid entry with allocated_rob_entries[rd_tag]=0 SHALL be invalidated at the next edge, SHALL NOT be selected this cycle, and its age state SHALL be cleared.
REQ-017 Simultaneous allocate, issue, flush and wakeup in one cycle SHALL all take effect, each on its own entry.
REQ-018 While start_exe=0, alu_data.src1_data and src2_data SHALL be 0.

Reset
REQ-019 On the rising edge of clk with rst_n=0, all entries SHALL become invalid and all age state SHALL be cleared.
REQ-020 During and after reset: res_empty=1, res_full=0, start_exe=0, all flags=0, alu_data src data=0.
REQ-021 Reset mid-operation SHALL discard pending entries without issuing them; load_word during reset SHALL be ignored.

Configuration
REQ-022 Macro RS_CDB_BYPASS_EN:
- Defined: an operand with robs_calculated[tag]=1 in the current cycle counts as valid for readiness, and alu_data takes cdb[tag].data combinationally (same-cycle wakeup-issue).
- Undefined: readiness uses registered valid bits only, so wakeup-to-issue is at least 1 cycle.

Structure
REQ-023 res_word, alu_word, cdb_data and op encodings SHALL remain in package tomasula_types; no new package-level constants are required.
REQ-024 Age tracking SHALL be sub-module rs_age_matrix:
- DEPTH x DEPTH matrix.
- Inputs: alloc one-hot, free one-hot, ready vector.
- Output: one-hot oldest-ready.

Verification
REQ-025 Reset then idle: res_empty=1, start_exe=0 for 10 cycles.
REQ-026 Fill 4 ADDs with both sources valid, exe_ready=0:
- res_full=1 after the 4th load; a 5th load_word is dropped.
- Raise exe_ready: issue order = allocation order, one per cycle.
REQ-027 Entry A waits on tag 3, entry B (younger) is ready:
- B issues first.
- Pulse robs_calculated[3] with data 0x1234: A issues with src1_data=0x1234.
- Latency 1 cycle without RS_CDB_BYPASS_EN, 0 cycles with it.
REQ-028 Clear allocated_rob_entries[2] while an entry with rd_tag=2 waits: the entry is invalidated next cycle and never issues; other entries are unaffected.
REQ-029 JALR with funct3=3'b010 issues: alu_data.funct3=0, jalr_executed=1, ld_pc_to_cdb=1, update_br=0.
REQ-030 Same cycle: issue handshake, a new load, and flush of a third entry → count after the edge = previous count - 1.

Source files
------------

// File: rtl/tomasula_types_pkg.sv
// Shared Tomasulo datapath types: reservation-station word, ALU issue word, CDB slot, opcodes.
// Pure type package, no logic.
package tomasula_types;

  localparam int WORD_W    = 32;
  // Equals clog2 of the ROB size used by the reservation stations.
  localparam int ROB_TAG_W = 3;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

  typedef struct packed {
    opcode_t               op;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [ROB_TAG_W-1:0]  src1_tag;
    logic [WORD_W-1:0]     src1_data;
    logic                  src1_valid;
    logic [ROB_TAG_W-1:0]  src2_tag;
    logic [WORD_W-1:0]     src2_data;
    logic                  src2_valid;
    logic [ROB_TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0]     pc;
  } res_word;

  typedef struct packed {
    opcode_t               op;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [WORD_W-1:0]     src1_data;
    logic [WORD_W-1:0]     src2_data;
    logic [ROB_TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0]     pc;
  } alu_word;

  typedef struct packed {
    logic [WORD_W-1:0] data;
  } cdb_data;

endpackage

// File: rtl/reservation_station_array_age_matrix.sv
// Age matrix: older[r][c]=1 means entry r was allocated before entry c; picks the oldest ready entry.
// Oldest-ready is combinational from registered age state; alloc/free update at the next edge.
module rs_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0] older [DEPTH];

  // A new entry is younger than everything present; freeing wipes its row and column.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) older[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < DEPTH; c++) begin
          if (free[r] || free[c] || alloc[r] || r == c) older[r][c] <= 1'b0;
          else if (alloc[c])                            older[r][c] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int c = 0; c < DEPTH; c++) begin
      logic blocked;
      blocked = 1'b0;
      for (int r = 0; r < DEPTH; r++) blocked = blocked | (older[r][c] & ready[r]);
      oldest[c] = ready[c] & ~blocked;
    end
  end

endmodule

// File: rtl/reservation_station_array.sv
// Reservation station: CDB wakeup, oldest-ready issue to the ALU, ROB flush; RS_CDB_BYPASS_EN enables same-cycle wakeup-issue.
// Issue is combinational from registered entries; a presented op is held until exe_ready, full drops load_word.
module reservation_station_array
  import tomasula_types::*;
#(
  parameter int DEPTH    = 4,
  parameter int ROB_SIZE = 8,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_word,
  input  res_word             res_in,
  input  cdb_data             cdb [ROB_SIZE],
  input  logic [ROB_SIZE-1:0] robs_calculated,
  input  logic [ROB_SIZE-1:0] allocated_rob_entries,
  input  logic                exe_ready,
  output logic                res_full,
  output logic                res_empty,
  output logic                start_exe,
  output alu_word             alu_data,
  output logic                jalr_executed,
  output logic                ld_pc_to_cdb,
  output logic                update_br
);

  res_word          entries [DEPTH];
  res_word          wake_q  [DEPTH];
  res_word          wake_in;
  res_word          sel_word;
  logic [DEPTH-1:0] valid, live, flush, ready, op1_ok, op2_ok;
  logic [DEPTH-1:0] oldest, sel, alloc_oh, free_mask, hold_sel;
  logic             hold_vld, hold_ok, do_alloc, issue, found;
  logic [XLEN-1:0]  src1_val, src2_val;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake_q[i] = entries[i];
      if (!entries[i].src1_valid && robs_calculated[entries[i].src1_tag]) begin
        wake_q[i].src1_valid = 1'b1;
        wake_q[i].src1_data  = cdb[entries[i].src1_tag].data;
      end
      if (!entries[i].src2_valid && robs_calculated[entries[i].src2_tag]) begin
        wake_q[i].src2_valid = 1'b1;
        wake_q[i].src2_data  = cdb[entries[i].src2_tag].data;
      end
    end
    wake_in = res_in;
    if (!res_in.src1_valid && robs_calculated[res_in.src1_tag]) begin
      wake_in.src1_valid = 1'b1;
      wake_in.src1_data  = cdb[res_in.src1_tag].data;
    end
    if (!res_in.src2_valid && robs_calculated[res_in.src2_tag]) begin
      wake_in.src2_valid = 1'b1;
      wake_in.src2_data  = cdb[res_in.src2_tag].data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live[i]   = valid[i] & allocated_rob_entries[entries[i].rd_tag];
      flush[i]  = valid[i] & ~allocated_rob_entries[entries[i].rd_tag];
      op1_ok[i] = entries[i].src1_valid;
      op2_ok[i] = entries[i].src2_valid;
`ifdef RS_CDB_BYPASS_EN
      op1_ok[i] = op1_ok[i] | robs_calculated[entries[i].src1_tag];
      op2_ok[i] = op2_ok[i] | robs_calculated[entries[i].src2_tag];
`endif
      ready[i]  = rst_n & live[i] & op1_ok[i] & op2_ok[i];
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk    (clk),
    .rst_n  (rst_n),
    .alloc  (alloc_oh),
    .free   (free_mask),
    .ready  (ready),
    .oldest (oldest)
  );

  // An op left waiting on exe_ready keeps priority so alu_data cannot change under the ALU.
  assign hold_ok   = hold_vld & |(hold_sel & ready);
  assign sel       = hold_ok ? hold_sel : oldest;
  assign start_exe = |sel;
  assign issue     = start_exe & exe_ready;
  assign free_mask = (sel & {DEPTH{issue}}) | flush;

  assign res_full  = rst_n & (&valid);
  assign res_empty = ~rst_n | ~(|valid);
  assign do_alloc  = load_word & rst_n & ~(&valid);

  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !found) begin
        alloc_oh[i] = do_alloc;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid    <= '0;
      hold_vld <= 1'b0;
    end else begin
      hold_vld <= start_exe & ~exe_ready;
      for (int i = 0; i < DEPTH; i++) begin
        if (free_mask[i]) begin
          valid[i] <= 1'b0;
        end else if (alloc_oh[i]) begin
          valid[i]   <= 1'b1;
          entries[i] <= wake_in;
        end else if (valid[i]) begin
          entries[i] <= wake_q[i];
        end
      end
    end
    hold_sel <= sel;
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) sel_word = entries[i];
    end
    src1_val = sel_word.src1_data;
    src2_val = sel_word.src2_data;
`ifdef RS_CDB_BYPASS_EN
    if (!sel_word.src1_valid) src1_val = cdb[sel_word.src1_tag].data;
    if (!sel_word.src2_valid) src2_val = cdb[sel_word.src2_tag].data;
`endif
    alu_data           = '0;
    alu_data.op        = sel_word.op;
    alu_data.funct3    = (sel_word.op == OP_JAL || sel_word.op == OP_JALR) ? 3'b000 : sel_word.funct3;
    alu_data.funct7    = sel_word.funct7;
    alu_data.src1_data = start_exe ? src1_val : '0;
    alu_data.src2_data = start_exe ? src2_val : '0;
    alu_data.rd_tag    = sel_word.rd_tag;
    alu_data.pc        = sel_word.pc;
  end

  assign jalr_executed = start_exe & (sel_word.op == OP_JALR);
  assign update_br     = start_exe & (sel_word.op == OP_BRANCH);
  assign ld_pc_to_cdb  = start_exe & (sel_word.op inside {OP_JAL, OP_JALR, OP_BRANCH, OP_AUIPC, OP_LUI});

endmodule

// File: tb/tb_reservation_station_array.sv
// Scoreboard bench: age-ordered queue model predicts per-cycle status and issued ops; monitor compares at negedge.
module tb_reservation_station_array;
  import tomasula_types::*;

  localparam int DEPTH    = 4;
  localparam int ROB_SIZE = 8;
  localparam logic [ROB_SIZE-1:0] ALL = '1;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, load_word, exe_ready;
  res_word             res_in;
  cdb_data             cdb [ROB_SIZE];
  logic [ROB_SIZE-1:0] robs_calculated, allocated_rob_entries;
  logic                res_full, res_empty, start_exe, jalr_executed, ld_pc_to_cdb, update_br;
  alu_word             alu_data;
  logic [31:0]         cdb_next [ROB_SIZE];

  reservation_station_array #(.DEPTH(DEPTH), .ROB_SIZE(ROB_SIZE), .XLEN(32)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .load_word             (load_word),
    .res_in                (res_in),
    .cdb                   (cdb),
    .robs_calculated       (robs_calculated),
    .allocated_rob_entries (allocated_rob_entries),
    .exe_ready             (exe_ready),
    .res_full              (res_full),
    .res_empty             (res_empty),
    .start_exe             (start_exe),
    .alu_data              (alu_data),
    .jalr_executed         (jalr_executed),
    .ld_pc_to_cdb          (ld_pc_to_cdb),
    .update_br             (update_br)
  );

  typedef struct { int id; res_word w; } ment_t;
  typedef struct { logic start; logic full; logic empty; logic jalr; logic ldpc; logic upbr; alu_word alu; } exp_t;

  ment_t mq[$];
  exp_t  exp_q[$];
  int    hold_id = -1;
  int    next_id = 0;
  int    checks  = 0;
  int    errors  = 0;
  bit    running = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit entry_ready(res_word w);
    bit ok1, ok2;
    ok1 = w.src1_valid || (BYPASS && robs_calculated[w.src1_tag]);
    ok2 = w.src2_valid || (BYPASS && robs_calculated[w.src2_tag]);
    return allocated_rob_entries[w.rd_tag] && ok1 && ok2;
  endfunction

  function automatic res_word wake(res_word w);
    res_word r = w;
    if (!w.src1_valid && robs_calculated[w.src1_tag]) begin
      r.src1_valid = 1'b1; r.src1_data = cdb[w.src1_tag].data;
    end
    if (!w.src2_valid && robs_calculated[w.src2_tag]) begin
      r.src2_valid = 1'b1; r.src2_data = cdb[w.src2_tag].data;
    end
    return r;
  endfunction

  // Model: the station is a list in allocation order; the oldest ready op goes unless one is being held.
  task automatic model_step();
    exp_t  e;
    ment_t nq[$];
    ment_t m;
    int    pick, cnt;
    e.start = 0; e.full = 0; e.empty = 1; e.jalr = 0; e.ldpc = 0; e.upbr = 0; e.alu = '0;
    if (!rst_n) begin
      mq.delete();
      hold_id = -1;
      exp_q.push_back(e);
      return;
    end
    cnt     = mq.size();
    e.full  = (cnt == DEPTH);
    e.empty = (cnt == 0);
    pick    = -1;
    for (int k = 0; k < cnt; k++)
      if (mq[k].id == hold_id && entry_ready(mq[k].w)) pick = k;
    for (int k = 0; k < cnt; k++)
      if (pick < 0 && entry_ready(mq[k].w)) pick = k;
    if (pick >= 0) begin
      m = mq[pick];
      e.start          = 1;
      e.alu.op         = m.w.op;
      e.alu.funct3     = (m.w.op == OP_JAL || m.w.op == OP_JALR) ? 3'b000 : m.w.funct3;
      e.alu.funct7     = m.w.funct7;
      e.alu.src1_data  = m.w.src1_valid ? m.w.src1_data : cdb[m.w.src1_tag].data;
      e.alu.src2_data  = m.w.src2_valid ? m.w.src2_data : cdb[m.w.src2_tag].data;
      e.alu.rd_tag     = m.w.rd_tag;
      e.alu.pc         = m.w.pc;
      e.jalr           = (m.w.op == OP_JALR);
      e.upbr           = (m.w.op == OP_BRANCH);
      e.ldpc           = m.w.op inside {OP_JAL, OP_JALR, OP_BRANCH, OP_AUIPC, OP_LUI};
    end
    exp_q.push_back(e);
    for (int k = 0; k < cnt; k++) begin
      if (k == pick && exe_ready) continue;
      if (!allocated_rob_entries[mq[k].w.rd_tag]) continue;
      m   = mq[k];
      m.w = wake(m.w);
      nq.push_back(m);
    end
    if (load_word && cnt < DEPTH) begin
      m.id = next_id++;
      m.w  = wake(res_in);
      nq.push_back(m);
    end
    hold_id = (pick >= 0 && !exe_ready) ? mq[pick].id : -1;
    mq = nq;
  endtask

  task automatic cyc(input logic rst, input logic ld, input res_word w, input logic er,
                     input logic [ROB_SIZE-1:0] calc, input logic [ROB_SIZE-1:0] alive);
    @(posedge clk);
    #1;
    rst_n = rst; load_word = ld; res_in = w; exe_ready = er;
    robs_calculated = calc; allocated_rob_entries = alive;
    for (int s = 0; s < ROB_SIZE; s++) cdb[s].data = cdb_next[s];
    running = 1'b1;
    model_step();
  endtask

  task automatic idle(input int n, input logic er);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, '0, er, '0, ALL);
  endtask

  function automatic res_word mk(opcode_t op, logic [2:0] f3, logic [2:0] t1, logic [31:0] d1, logic v1,
                                 logic [2:0] t2, logic [31:0] d2, logic v2, logic [2:0] rd, logic [31:0] pc);
    res_word w;
    w.op = op; w.funct3 = f3; w.funct7 = 7'h20;
    w.src1_tag = t1; w.src1_data = d1; w.src1_valid = v1;
    w.src2_tag = t2; w.src2_data = d2; w.src2_valid = v2;
    w.rd_tag = rd; w.pc = pc;
    return w;
  endfunction

  function automatic res_word rnd_word();
    opcode_t ops [9];
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    return mk(ops[$urandom_range(0, 8)], 3'($urandom), 3'($urandom), $urandom, 1'($urandom),
              3'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (running) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_underflow at %0t: got no record expected one", $time);
        end else begin
          e = exp_q.pop_front();
          chk("start_exe", start_exe, e.start);
          chk("res_full", res_full, e.full);
          chk("res_empty", res_empty, e.empty);
          chk("jalr_executed", jalr_executed, e.jalr);
          chk("ld_pc_to_cdb", ld_pc_to_cdb, e.ldpc);
          chk("update_br", update_br, e.upbr);
          if (e.start) chk("alu_data", alu_data, e.alu);
          else begin
            chk("idle_src1_data", alu_data.src1_data, 0);
            chk("idle_src2_data", alu_data.src2_data, 0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [ROB_SIZE-1:0] calc, alive;
    rst_n = 1'b0; load_word = 1'b0; res_in = '0; exe_ready = 1'b0;
    robs_calculated = '0; allocated_rob_entries = ALL;
    for (int s = 0; s < ROB_SIZE; s++) begin cdb[s].data = '0; cdb_next[s] = '0; end

    // Reset with a load that must be ignored, then idle.
    cyc(1'b0, 1'b1, mk(OP_REG, 0, 0, 1, 1, 0, 2, 1, 1, 0), 1'b1, '0, ALL);
    cyc(1'b0, 1'b1, mk(OP_REG, 0, 0, 1, 1, 0, 2, 1, 1, 0), 1'b1, '0, ALL);
    idle(10, 1'b1);

    // Fill with ready ADDs while the ALU stalls; fifth load dropped; drain in order.
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 1'b1, mk(OP_REG, 0, 0, 32'h100 + k, 1, 1, 32'h200 + k, 1, 3'(k), 32'h1000 + 4 * k), 1'b0, '0, ALL);
    idle(1, 1'b0);
    idle(6, 1'b1);

    // Older entry waits on tag 3; younger ready entry goes first.
    cyc(1'b1, 1'b1, mk(OP_REG, 0, 3, 0, 0, 0, 5, 1, 4, 32'h2000), 1'b1, '0, ALL);
    cyc(1'b1, 1'b1, mk(OP_REG, 0, 0, 7, 1, 0, 8, 1, 5, 32'h2004), 1'b1, '0, ALL);
    idle(2, 1'b1);
    cdb_next[3] = 32'h1234;
    cyc(1'b1, 1'b0, '0, 1'b1, 8'b0000_1000, ALL);
    cdb_next[3] = 32'h0;
    idle(3, 1'b1);

    // ROB flush of tag 2 while its entry waits.
    cyc(1'b1, 1'b1, mk(OP_REG, 0, 6, 0, 0, 0, 1, 1, 2, 32'h3000), 1'b0, '0, ALL);
    cyc(1'b1, 1'b1, mk(OP_IMM, 1, 0, 9, 1, 0, 4, 1, 1, 32'h3004), 1'b0, '0, ALL);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, ALL & ~8'h04);
    idle(4, 1'b1);

    cyc(1'b1, 1'b1, mk(OP_JALR, 3'b010, 0, 32'h40, 1, 0, 32'h4, 1, 3, 32'h4000), 1'b1, '0, ALL);
    idle(3, 1'b1);

    // Issue, allocate and flush in the same cycle.
    cyc(1'b1, 1'b1, mk(OP_BRANCH, 1, 0, 5, 1, 0, 5, 1, 1, 32'h5000), 1'b0, '0, ALL);
    cyc(1'b1, 1'b1, mk(OP_REG, 0, 6, 0, 0, 0, 1, 1, 2, 32'h5004), 1'b0, '0, ALL);
    cyc(1'b1, 1'b1, mk(OP_LUI, 2, 0, 3, 1, 0, 3, 1, 3, 32'h5008), 1'b1, '0, ALL & ~8'h04);
    idle(4, 1'b1);

    for (int n = 0; n < 1500; n++) begin
      for (int s = 0; s < ROB_SIZE; s++) begin
        cdb_next[s] = $urandom;
        calc[s]     = ($urandom_range(0, 99) < 15);
        alive[s]    = ($urandom_range(0, 99) >= 3);
      end
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 55), rnd_word(),
          ($urandom_range(0, 99) < 60), calc, alive);
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
